// File: rtl/idecode.sv
// IF/ID pipeline register, MIPS-subset decoder and load-use hazard stall.
// Optional IDECODE_ILLEGAL_TRAP_EN adds a sticky `illegal` output that halts fetch.
module idecode #(
   parameter int W    = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [W-1:0]    if_pc,
   input  logic [W-1:0]    if_instr,
   input  logic            if_valid,
   input  logic            flush,
   input  logic            stall_in,
   output logic            write_pc,
   output logic            is_branch,
   output logic            is_jump,
   output logic [15:0]     branch_addr,
   output logic [25:0]     jump_addr,
   output logic            id_valid,
   output logic [W-1:0]    id_pc,
   output logic [RA_W-1:0] rs,
   output logic [RA_W-1:0] rt,
   output logic [RA_W-1:0] rd,
   output logic [W-1:0]    imm_sext,
   output logic [2:0]      alu_op,
   output logic            alu_src,
   output logic            reg_dst,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
`ifdef IDECODE_ILLEGAL_TRAP_EN
   output logic            is_jr,
   output logic            illegal
`else
   output logic            is_jr
`endif
);

   typedef enum logic {IDLE, BUBBLE} hz_state_t;

   hz_state_t      state, state_nxt;
   logic [W-1:0]   id_instr;
   logic           id_valid_r;
   logic           valid_q;
   logic           halt;
   logic           unknown;
   logic           hazard;
   logic           hold;
   logic           take_bubble;
   logic [5:0]     opcode, funct, if_op;

`ifdef IDECODE_ILLEGAL_TRAP_EN
   logic illegal_r;
   assign illegal = illegal_r;
   assign halt    = illegal_r;
`else
   assign halt = 1'b0;
`endif

   assign valid_q     = id_valid_r & ~halt;
   assign id_valid    = valid_q;
   assign opcode      = id_instr[31:26];
   assign funct       = id_instr[5:0];
   assign if_op       = if_instr[31:26];
   assign rs          = id_instr[25:21];
   assign rt          = id_instr[20:16];
   assign rd          = id_instr[15:11];
   assign branch_addr = id_instr[15:0];
   assign jump_addr   = id_instr[25:0];
   assign imm_sext    = {{(W-16){id_instr[15]}}, id_instr[15:0]};

   always_comb begin
      is_branch = 1'b0;
      is_jump   = 1'b0;
      alu_op    = 3'd0;
      alu_src   = 1'b0;
      reg_dst   = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      is_jr     = 1'b0;
      unknown   = 1'b0;
      if (valid_q) begin
         case (opcode)
            6'h00: begin
               case (funct)
                  6'h20: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 3'd0; end
                  6'h22: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 3'd1; end
                  6'h2A: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 3'd3; end
                  6'h08: is_jr = 1'b1;
                  default: unknown = 1'b1;
               endcase
            end
            6'h23: begin alu_src = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
            6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
            6'h08: begin alu_src = 1'b1; reg_write = 1'b1; end
            6'h0E: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 3'd2; end
            6'h04, 6'h05: begin is_branch = 1'b1; alu_op = 3'd1; end
            6'h02: is_jump = 1'b1;
            6'h03: begin is_jump = 1'b1; reg_write = 1'b1; end
            default: unknown = 1'b1;
         endcase
      end
   end

   // rt of the incoming word only matters for opcodes that read it as a source.
   assign hazard = mem_read && (rt != '0) && if_valid &&
                   ((if_instr[25:21] == rt) ||
                    ((if_instr[20:16] == rt) &&
                     (if_op == 6'h00 || if_op == 6'h04 || if_op == 6'h05 || if_op == 6'h2B)));

   always_comb begin
      state_nxt   = state;
      write_pc    = 1'b1;
      hold        = 1'b0;
      take_bubble = 1'b0;
      if (halt) begin
         write_pc = 1'b0;
         hold     = 1'b1;
      end else if (flush) begin
         state_nxt = IDLE;
      end else if (stall_in) begin
         write_pc = 1'b0;
         hold     = 1'b1;
      end else if (state == IDLE && hazard) begin
         state_nxt   = BUBBLE;
         write_pc    = 1'b0;
         take_bubble = 1'b1;
      end else if (state == BUBBLE) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         id_valid_r <= 1'b0;
         id_instr   <= '0;
         id_pc      <= '0;
      end else begin
         state <= state_nxt;
         if (flush && !halt) begin
            id_valid_r <= 1'b0;
         end else if (take_bubble) begin
            id_valid_r <= 1'b0;
         end else if (!hold) begin
            id_instr   <= if_instr;
            id_pc      <= if_pc;
            id_valid_r <= if_valid;
         end
      end
   end

`ifdef IDECODE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset)        illegal_r <= 1'b0;
      else if (unknown) illegal_r <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: directed spec cases plus randomized stimulus
// against a table-driven reference decoder and a simple ID-register model.
module tb_idecode;

   logic        clk = 1'b0;
   logic        reset, if_valid, flush, stall_in;
   logic [31:0] if_pc, if_instr;
   logic        write_pc, is_branch, is_jump, id_valid;
   logic [15:0] branch_addr;
   logic [25:0] jump_addr;
   logic [31:0] id_pc, imm_sext;
   logic [4:0]  rs, rt, rd;
   logic [2:0]  alu_op;
   logic        alu_src, reg_dst, reg_write, mem_read, mem_write, is_jr;
`ifdef IDECODE_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   idecode #(.W(32), .RA_W(5)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
      .if_valid(if_valid), .flush(flush), .stall_in(stall_in),
      .write_pc(write_pc), .is_branch(is_branch), .is_jump(is_jump),
      .branch_addr(branch_addr), .jump_addr(jump_addr), .id_valid(id_valid),
      .id_pc(id_pc), .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext),
      .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
`ifdef IDECODE_ILLEGAL_TRAP_EN
      .is_jr(is_jr), .illegal(illegal)
`else
      .is_jr(is_jr)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       br, jp;
      logic [2:0] alu;
      logic       src, dst, wr, mr, mw, jr;
   } ctl_t;

   ctl_t op_tab [64];
   logic op_ok  [64];
   ctl_t fn_tab [64];
   logic fn_ok  [64];

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic        m_valid;
   logic [31:0] m_instr, m_pc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic build_tables();
      for (int i = 0; i < 64; i++) begin
         op_tab[i] = '0; op_ok[i] = 1'b0; fn_tab[i] = '0; fn_ok[i] = 1'b0;
      end
      //                 br    jp    alu   src   dst   wr    mr    mw    jr
      op_tab[6'h23] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      op_tab[6'h2B] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      op_tab[6'h08] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      op_tab[6'h0E] = '{1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      op_tab[6'h04] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      op_tab[6'h05] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      op_tab[6'h02] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      op_tab[6'h03] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      fn_tab[6'h20] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      fn_tab[6'h22] = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      fn_tab[6'h2A] = '{1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      fn_tab[6'h08] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      foreach (op_tab[i]) op_ok[i] = (op_tab[i] != '0);
      foreach (fn_tab[i]) fn_ok[i] = (fn_tab[i] != '0);
   endtask

   function automatic ctl_t ref_ctl();
      ctl_t e = '0;
      if (m_valid) begin
         if (m_instr[31:26] == 6'd0) begin
            if (fn_ok[m_instr[5:0]]) e = fn_tab[m_instr[5:0]];
         end else if (op_ok[m_instr[31:26]]) begin
            e = op_tab[m_instr[31:26]];
         end
      end
      return e;
   endfunction

   // Load-use: the ID instruction is a valid LW whose destination the incoming word reads.
   function automatic logic ref_hazard();
      int unsigned dst = m_instr[20:16];
      int unsigned op  = if_instr[31:26];
      logic reads_rt   = (op == 0 || op == 4 || op == 5 || op == 'h2B);
      if (!(m_valid && m_instr[31:26] == 6'h23 && dst != 0 && if_valid)) return 1'b0;
      return (if_instr[25:21] == dst) || (reads_rt && if_instr[20:16] == dst);
   endfunction

   task automatic compare_all();
      ctl_t e = ref_ctl();
      logic exp_wpc = flush ? 1'b1 : stall_in ? 1'b0 : !ref_hazard();
      check("write_pc",  write_pc,  exp_wpc);
      check("id_valid",  id_valid,  m_valid);
      check("id_pc",     id_pc,     m_pc);
      check("rs",        rs,        (m_instr >> 21) & 31);
      check("rt",        rt,        (m_instr >> 16) & 31);
      check("rd",        rd,        (m_instr >> 11) & 31);
      check("imm_sext",  imm_sext,  32'($signed(m_instr[15:0])));
      check("br_addr",   branch_addr, m_instr % 65536);
      check("j_addr",    jump_addr, m_instr % (1 << 26));
      check("is_branch", is_branch, e.br);
      check("is_jump",   is_jump,   e.jp);
      check("alu_op",    alu_op,    e.alu);
      check("alu_src",   alu_src,   e.src);
      check("reg_dst",   reg_dst,   e.dst);
      check("reg_write", reg_write, e.wr);
      check("mem_read",  mem_read,  e.mr);
      check("mem_write", mem_write, e.mw);
      check("is_jr",     is_jr,     e.jr);
`ifdef IDECODE_ILLEGAL_TRAP_EN
      check("illegal",   illegal,   1'b0);
`endif
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                       input logic v, input logic fl, input logic st);
      logic hz;
      @(negedge clk);
      if_instr = ins; if_pc = pc; if_valid = v; flush = fl; stall_in = st;
      #1;
      compare_all();
      hz = ref_hazard();
      if (fl)       m_valid = 1'b0;
      else if (st)  ;
      else if (hz)  m_valid = 1'b0;
      else begin m_instr = ins; m_pc = pc; m_valid = v; end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; if_valid = 1'b0; flush = 1'b0; stall_in = 1'b0;
      if_instr = '0; if_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      m_valid = 1'b0; m_instr = '0; m_pc = '0;
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0E, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
      logic [5:0] fns [5]  = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h26};
      logic [31:0] w = $urandom;
      w[31:26] = ops[$urandom_range(0, 9)];
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 3)];
`ifndef IDECODE_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) w = $urandom;
      if (w[31:26] == 6'h00 && $urandom_range(0, 4) == 0) w[5:0] = 6'h26;
`endif
      return w;
   endfunction

   initial begin
      logic [31:0] pc;
      build_tables();
      do_reset();

      step(32'h0108_4820, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
      check("add_rs", rs, 8);
      check("add_rt", rt, 8);
      check("add_rd", rd, 9);
      check("add_reg_dst", reg_dst, 1);
      check("add_reg_write", reg_write, 1);
      check("add_alu_op", alu_op, 0);

      step(32'h8C08_0000, 32'h0000_0014, 1'b1, 1'b0, 1'b0);
      check("lw_mem_read", mem_read, 1);
      step(32'h0108_4820, 32'h0000_0018, 1'b1, 1'b0, 1'b0);
      check("lu_bubble", id_valid, 0);
      step(32'h0108_4820, 32'h0000_0018, 1'b1, 1'b0, 1'b0);
      check("lu_add_valid", id_valid, 1);
      check("lu_add_rd", rd, 9);
      check("lu_add_pc", id_pc, 32'h18);

      step(32'h1422_FFFF, 32'h0000_001C, 1'b1, 1'b0, 1'b0);
      check("bne_branch", is_branch, 1);
      check("bne_addr", branch_addr, 16'hFFFF);
      check("bne_sext", imm_sext, 32'hFFFF_FFFF);

      step(32'h0800_0007, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
      check("j_is_jump", is_jump, 1);
      check("j_addr7", jump_addr, 7);
      step(32'h0000_0000, 32'h0000_0024, 1'b1, 1'b1, 1'b0);
      check("flush_kill", id_valid, 0);

      step(32'h0108_4820, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(32'h2002_0005 + i, 32'h0000_0200 + 4 * i, 1'b1, 1'b0, 1'b1);
         check("stall_pc", id_pc, 32'h100);
         check("stall_rd", rd, 9);
         check("stall_wpc", write_pc, 0);
      end

      pc = 32'h1000;
      for (int i = 0; i < 600; i++) begin
         logic fl = ($urandom_range(0, 15) == 0);
         logic st = ($urandom_range(0, 9) == 0);
         step(rand_instr(), pc, ($urandom_range(0, 7) != 0), fl, st);
         pc += 4;
      end

`ifdef IDECODE_ILLEGAL_TRAP_EN
      do_reset();
      @(negedge clk);
      if_instr = 32'hFC00_0000; if_valid = 1'b1; flush = 1'b0; stall_in = 1'b0;
      @(posedge clk); #1;
      check("trap_pre", illegal, 0);
      @(negedge clk);
      if_instr = 32'h0108_4820;
      @(posedge clk); #1;
      check("trap_set", illegal, 1);
      repeat (3) @(posedge clk);
      #1;
      check("trap_sticky", illegal, 1);
      check("trap_idv", id_valid, 0);
      check("trap_wpc", write_pc, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("trap_clr", illegal, 0);
      reset = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
